servo_pwm_gen: RTL and testbench

SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

---
 rtl/servo_pwm_gen.sv | 117 +++++++++++
 tb/tb_servo_pwm_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// Servo PWM frame generator: one pulse of programmable width per fixed-length frame.
module servo_pwm_gen #(
  parameter int unsigned N             = 8,
  parameter int unsigned PERIOD_CYCLES = 200000,
  parameter int unsigned MIN_CYCLES    = 10000,
  parameter int unsigned STEP          = 39,
  parameter int unsigned CNT_W         = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data,
  input  logic         en,
  output logic         pwm,
  output logic         busy,
  output logic         period_start
);

  // Width arithmetic is done wide enough that MIN + data*STEP cannot wrap.
  localparam int unsigned       WW       = CNT_W + N;
  localparam logic [WW-1:0]     LIMIT_W  = WW'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] width_next;
  logic             pwm_next;
  logic             busy_next;
  logic             period_start_next;

  logic [WW-1:0]    width_raw_c;
  logic [CNT_W-1:0] width_new_c;

  // Pulse width for a new frame from the current position command, clamped so LOW lasts >= 1 cycle.
  always_comb begin
    width_raw_c = WW'(MIN_CYCLES) + (WW'(data) * WW'(STEP));
    width_new_c = (width_raw_c > LIMIT_W) ? LAST_CNT : width_raw_c[CNT_W-1:0];
  end

  // Next-state, counter, width latch and next output values.
  always_comb begin
    state_next        = state;
    cnt_next          = cnt;
    width_next        = width;
    period_start_next = 1'b0;

    case (state)
      IDLE: begin
        if (en) begin
          state_next        = HIGH;
          cnt_next          = '0;
          width_next        = width_new_c;
          period_start_next = 1'b1;
        end
      end

      HIGH: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == (width - CNT_W'(1))) begin
          state_next = LOW;
        end
      end

      LOW: begin
        if (cnt == LAST_CNT) begin
          cnt_next = '0;
          if (en) begin
            state_next        = HIGH;
            width_next        = width_new_c;
            period_start_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they come straight out of flops.
    pwm_next  = (state_next == HIGH);
    busy_next = (state_next != IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      width        <= '0;
      pwm          <= 1'b0;
      busy         <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      width        <= width_next;
      pwm          <= pwm_next;
      busy         <= busy_next;
      period_start <= period_start_next;
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen with a frame-level reference model.
module tb_servo_pwm_gen;

  localparam int unsigned N   = 8;
  localparam int unsigned P   = 100;
  localparam int unsigned MIN = 10;
  localparam int unsigned STP = 1;
  localparam int unsigned CW  = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] data;
  logic         en;
  logic         pwm;
  logic         busy;
  logic         period_start;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  servo_pwm_gen #(
    .N(N), .PERIOD_CYCLES(P), .MIN_CYCLES(MIN), .STEP(STP), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .en(en),
    .pwm(pwm), .busy(busy), .period_start(period_start)
  );

  always #50 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is P cycles long, pwm high for its first fw cycles.
  bit in_frame = 1'b0;
  int pos = 0;
  int fw  = 0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      in_frame = 1'b0;
    end else if (in_frame && pos < int'(P) - 1) begin
      pos++;
    end else if (en) begin
      in_frame = 1'b1;
      pos = 0;
      fw = int'(MIN) + int'(data) * int'(STP);
      if (fw > int'(P) - 1) fw = int'(P) - 1;
    end else begin
      in_frame = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pwm", 32'(pwm), 32'(in_frame && pos < fw));
      check("busy", 32'(busy), 32'(in_frame));
      check("period_start", 32'(period_start), 32'(in_frame && pos == 0));
    end
  end

  // Measure pwm/busy run lengths and strobe times directly from the DUT.
  int pulse_q[$];
  int busy_q[$];
  int ps_q[$];
  int pw_run = 0;
  int bz_run = 0;

  always @(negedge clk) begin
    if (pwm === 1'b1) pw_run++;
    else if (pw_run > 0) begin pulse_q.push_back(pw_run); pw_run = 0; end
    if (busy === 1'b1) bz_run++;
    else if (bz_run > 0) begin busy_q.push_back(bz_run); bz_run = 0; end
    if (period_start === 1'b1) ps_q.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic window(input int n, output int pw, output int bz, output int ps);
    pw = 0; bz = 0; ps = 0;
    for (int i = 0; i < n; i++) begin
      if (pwm === 1'b1) pw++;
      if (busy === 1'b1) bz++;
      if (period_start === 1'b1) ps++;
      @(negedge clk);
    end
  endtask

  task automatic clear_q();
    pulse_q.delete();
    busy_q.delete();
    ps_q.delete();
  endtask

  int pw_c, bz_c, ps_c;

  initial begin
    reset = 1'b1; en = 1'b0; data = '0;
    step(2);
    chk_en = 1'b1;
    step(1);
    check("reset_pwm", 32'(pwm), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ps", 32'(period_start), 32'd0);

    // Idle with en low
    reset = 1'b0;
    window(500, pw_c, bz_c, ps_c);
    check("idle_pwm_cnt", 32'(pw_c), 32'd0);
    check("idle_busy_cnt", 32'(bz_c), 32'd0);
    check("idle_ps_cnt", 32'(ps_c), 32'd0);

    // Single en pulse, data=20
    clear_q();
    data = 8'd20; en = 1'b1;
    step(1);
    en = 1'b0;
    window(120, pw_c, bz_c, ps_c);
    check("single_pwm_cnt", 32'(pw_c), 32'd30);
    check("single_busy_cnt", 32'(bz_c), 32'd100);
    check("single_ps_cnt", 32'(ps_c), 32'd1);
    check("single_pulses", 32'(pulse_q.size()), 32'd1);
    if (pulse_q.size() == 1) check("single_pulse_len", 32'(pulse_q[0]), 32'd30);

    // en held, data changed mid-frame
    clear_q();
    data = 8'd20; en = 1'b1;
    step(16);
    data = 8'd50;
    step(100);
    en = 1'b0;
    step(150);
    check("hold_pulses", 32'(pulse_q.size()), 32'd2);
    if (pulse_q.size() == 2) begin
      check("hold_pulse1", 32'(pulse_q[0]), 32'd30);
      check("hold_pulse2", 32'(pulse_q[1]), 32'd60);
    end
    check("hold_strobes", 32'(ps_q.size()), 32'd2);
    if (ps_q.size() == 2) check("hold_strobe_gap", 32'(ps_q[1] - ps_q[0]), 32'd100);
    check("hold_busy_runs", 32'(busy_q.size()), 32'd1);
    if (busy_q.size() == 1) check("hold_busy_len", 32'(busy_q[0]), 32'd200);

    // Minimum and clamped widths
    clear_q();
    data = 8'd0; en = 1'b1;
    step(1);
    en = 1'b0;
    step(110);
    data = 8'd200; en = 1'b1;
    step(1);
    en = 1'b0;
    window(110, pw_c, bz_c, ps_c);
    check("clamp_pwm_cnt", 32'(pw_c), 32'd99);
    check("clamp_busy_cnt", 32'(bz_c), 32'd100);
    check("clamp_ps_cnt", 32'(ps_c), 32'd1);
    check("minclamp_pulses", 32'(pulse_q.size()), 32'd2);
    if (pulse_q.size() == 2) begin
      check("min_pulse", 32'(pulse_q[0]), 32'd10);
      check("clamp_pulse", 32'(pulse_q[1]), 32'd99);
    end

    // Reset mid-pulse, then restart
    clear_q();
    data = 8'd40; en = 1'b1;
    step(13);
    reset = 1'b1;
    step(1);
    check("abort_pwm", 32'(pwm), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    step(2);
    check("abort_hold_ps", 32'(period_start), 32'd0);
    reset = 1'b0;
    step(1);
    check("restart_ps", 32'(period_start), 32'd1);
    check("restart_pwm", 32'(pwm), 32'd1);
    step(10);
    en = 1'b0;
    step(150);
    check("abort_pulses", 32'(pulse_q.size()), 32'd2);
    if (pulse_q.size() == 2) begin
      check("abort_pulse1", 32'(pulse_q[0]), 32'd13);
      check("restart_pulse", 32'(pulse_q[1]), 32'd50);
    end

    // en dropped early in the frame
    clear_q();
    data = 8'd20; en = 1'b1;
    step(6);
    en = 1'b0;
    step(150);
    check("drop_pulses", 32'(pulse_q.size()), 32'd1);
    if (pulse_q.size() == 1) check("drop_pulse", 32'(pulse_q[0]), 32'd30);
    check("drop_busy_runs", 32'(busy_q.size()), 32'd1);
    if (busy_q.size() == 1) check("drop_busy_len", 32'(busy_q[0]), 32'd100);
    check("drop_strobes", 32'(ps_q.size()), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
